// File: rtl/jk_pkg.sv
// Shared definitions for the JK command sequencer: op and state encodings,
// the packed command format, and the next-q rule of a JK stage.
package jk_pkg;

  localparam int CMD_W = 6;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_DRIVE = 2'b01,
    S_GAP   = 2'b10
  } seq_state_e;

  typedef struct packed {
    jk_op_e     op;
    logic [3:0] cnt;
  } jk_cmd_t;

  // {j,k} equals the op encoding, so the op alone decides the next q.
  function automatic logic jk_next(jk_op_e op, logic q);
    logic nq;
    nq = q;
    case (op)
      JK_RESET:  nq = 1'b0;
      JK_SET:    nq = 1'b1;
      JK_TOGGLE: nq = ~q;
      default:   nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Command FIFO for the JK sequencer: DEPTH entries (power of two, >= 2),
// extra-MSB pointers, head visible combinationally on rd_cmd.
module jk_cmd_fifo
  import jk_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  jk_cmd_t wr_cmd,
  output jk_cmd_t rd_cmd,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  jk_cmd_t     mem [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_cmd;
  end

  assign rd_cmd = mem[rd_ptr[AW-1:0]];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Queues hold/reset/set/toggle commands and plays each out as a timed j/k
// waveform plus a hold gap. Optional q self-check under JK_SEQ_CHECK_EN.
module jk_cmd_sequencer
  import jk_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int GAP_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_cnt,
  output logic       j,
  output logic       k,
  output logic       busy,
  output logic       done,
  input  logic       q_in,
  output logic       err
);

  localparam bit         HAS_GAP  = (GAP_CYC > 0);
  localparam logic [3:0] GAP_LOAD = 4'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  seq_state_e state;
  logic [3:0] cnt;
  jk_op_e     op;
  jk_cmd_t    head;
  jk_cmd_t    wr_cmd;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       last_cyc;

  assign wr_cmd    = '{op: jk_op_e'(cmd_op), cnt: cmd_cnt};
  assign push      = cmd_valid && !fifo_full;
  assign pop       = (state == S_IDLE) && !fifo_empty;
  assign cmd_ready = !fifo_full;
  assign busy      = (state != S_IDLE) || !fifo_empty;
  assign last_cyc  = (cnt == 4'd0) &&
                     ((state == S_GAP) || (!HAS_GAP && (state == S_DRIVE)));

  jk_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .wr_cmd (wr_cmd),
    .rd_cmd (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // j/k/done are registered decodes of the current state, so the waveform
  // trails the FSM by one cycle and never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      op    <= JK_HOLD;
      j     <= 1'b0;
      k     <= 1'b0;
      done  <= 1'b0;
    end else begin
      j    <= (state == S_DRIVE) && op[1];
      k    <= (state == S_DRIVE) && op[0];
      done <= last_cyc;
      unique case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            state <= S_DRIVE;
            op    <= head.op;
            cnt   <= head.cnt;
          end
        end
        S_DRIVE: begin
          if (cnt == 4'd0) begin
            if (HAS_GAP) begin
              state <= S_GAP;
              cnt   <= GAP_LOAD;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_GAP: begin
          if (cnt == 4'd0) state <= S_IDLE;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef JK_SEQ_CHECK_EN
  logic exp_q;
  logic exp_q_d;
  logic chk_armed;

  // The stage sees j/k one cycle after DRIVE, so q_in lines up with exp_q_d.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q     <= 1'b0;
      exp_q_d   <= 1'b0;
      chk_armed <= 1'b0;
      err       <= 1'b0;
    end else begin
      chk_armed <= 1'b1;
      exp_q_d   <= exp_q;
      if (state == S_DRIVE) exp_q <= jk_next(op, exp_q);
      if (chk_armed && (state != S_DRIVE) && (q_in != exp_q_d)) err <= 1'b1;
    end
  end
`else
  logic unused_q_in;
  assign unused_q_in = q_in;
  assign err         = 1'b0;
`endif

endmodule
